// File: rtl/param_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : param_control_unit
//  Description : Multi-cycle control FSM for a small register-file CPU.
//                Decodes the IR contents and sequences fetch, decode and
//                one- or two-step execute phases, emitting datapath strobes,
//                bus selects and memory requests. All outputs are decoded
//                combinationally from the state, the instruction and the
//                inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_control_unit #(
  parameter int NUM_REGS = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [4+2*$clog2(NUM_REGS)-1:0]        instruction,
  input  logic                                   zflag,
  input  logic                                   oflag,
  input  logic                                   mem_ready,
  input  logic                                   halt,
  output logic [NUM_REGS-1:0]                    load_reg,
  output logic                                   load_ir,
  output logic                                   load_pc,
  output logic                                   inc_pc,
  output logic                                   load_add_reg,
  output logic                                   load_reg_y,
  output logic                                   load_flags,
  output logic                                   mem_read,
  output logic                                   mem_write,
  output logic [$clog2(NUM_REGS):0]              sel_bus_1,
  output logic [1:0]                             sel_bus_2,
  output logic                                   halted,
  output logic                                   instr_done
);

  localparam int RSEL_W  = $clog2(NUM_REGS);
  localparam int INSTR_W = 4 + 2 * RSEL_W;

  // FSM state encoding
  localparam logic [2:0] ST_FETCH1 = 3'd0;
  localparam logic [2:0] ST_FETCH2 = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC1  = 3'd3;
  localparam logic [2:0] ST_EXEC2  = 3'd4;

  // Opcodes; 0..5 form the ALU group
  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_NOT    = 4'd3;
  localparam logic [3:0] OP_OR     = 4'd5;
  localparam logic [3:0] OP_NOP    = 4'd6;
  localparam logic [3:0] OP_REGD   = 4'd7;
  localparam logic [3:0] OP_REGI   = 4'd8;
  localparam logic [3:0] OP_READ   = 4'd9;
  localparam logic [3:0] OP_READI  = 4'd10;
  localparam logic [3:0] OP_WRITE  = 4'd11;
  localparam logic [3:0] OP_WRITEI = 4'd12;
  localparam logic [3:0] OP_JMP    = 4'd13;
  localparam logic [3:0] OP_JIZ    = 4'd14;
  localparam logic [3:0] OP_JIO    = 4'd15;

  // Bus-1 select values: registers are 0..NUM_REGS-1, the PC sits just above
  localparam logic [RSEL_W:0] SEL_PC = (RSEL_W+1)'(NUM_REGS);

  // Bus-2 select values
  localparam logic [1:0] SEL2_ALU  = 2'd0;
  localparam logic [1:0] SEL2_BUS1 = 2'd1;
  localparam logic [1:0] SEL2_MEM  = 2'd2;

  logic [2:0]          state_q;
  logic [2:0]          state_d;

  logic [3:0]          w_opcode;
  logic [RSEL_W-1:0]   w_dst;
  logic [RSEL_W-1:0]   w_src;
  logic [RSEL_W:0]     w_sel_dst;
  logic [RSEL_W:0]     w_sel_src;
  logic [NUM_REGS-1:0] w_dst_hot;
  logic                w_is_alu;
  logic                w_jmp_taken;

  // Instruction field split: {opcode, dst, src}
  assign w_opcode  = instruction[INSTR_W-1 -: 4];
  assign w_dst     = instruction[2*RSEL_W-1 -: RSEL_W];
  assign w_src     = instruction[RSEL_W-1:0];
  assign w_sel_dst = {1'b0, w_dst};
  assign w_sel_src = {1'b0, w_src};
  assign w_is_alu  = (w_opcode <= OP_OR);

  // Flags are looked at combinationally, so they are sampled in the very
  // cycle the jump-target read completes.
  assign w_jmp_taken = (w_opcode == OP_JMP) ||
                       ((w_opcode == OP_JIZ) && zflag) ||
                       ((w_opcode == OP_JIO) && oflag);

  // One-hot decode of the destination register field
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_dst_dec
    assign w_dst_hot[i] = (w_dst == RSEL_W'(i));
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    load_reg     = '0;
    load_ir      = 1'b0;
    load_pc      = 1'b0;
    inc_pc       = 1'b0;
    load_add_reg = 1'b0;
    load_reg_y   = 1'b0;
    load_flags   = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    sel_bus_1    = '0;
    sel_bus_2    = SEL2_ALU;
    halted       = 1'b0;
    instr_done   = 1'b0;

    case (state_q)
      ST_FETCH1: begin
        // A pending halt parks the FSM here with every strobe quiet
        if (halt) begin
          halted = 1'b1;
        end else begin
          sel_bus_1    = SEL_PC;
          load_add_reg = 1'b1;
          state_d      = ST_FETCH2;
        end
      end

      ST_FETCH2: begin
        mem_read  = 1'b1;
        sel_bus_2 = SEL2_MEM;
        if (mem_ready) begin
          load_ir = 1'b1;
          inc_pc  = 1'b1;
          state_d = ST_DECODE;
        end
      end

      ST_DECODE: begin
        if (w_is_alu) begin
          // First operand (dst) goes into the ALU Y latch
          sel_bus_1  = w_sel_dst;
          load_reg_y = 1'b1;
          state_d    = ST_EXEC1;
        end else begin
          case (w_opcode)
            OP_NOP: begin
              instr_done = 1'b1;
              state_d    = ST_FETCH1;
            end
            OP_REGD: begin
              // Register-to-register move completes in decode
              sel_bus_1  = w_sel_src;
              sel_bus_2  = SEL2_BUS1;
              load_reg   = w_dst_hot;
              instr_done = 1'b1;
              state_d    = ST_FETCH1;
            end
            OP_READ: begin
              sel_bus_1    = w_sel_src;
              load_add_reg = 1'b1;
              state_d      = ST_EXEC1;
            end
            OP_WRITE: begin
              sel_bus_1    = w_sel_dst;
              load_add_reg = 1'b1;
              state_d      = ST_EXEC1;
            end
            default: begin
              // REGI/READI/WRITEI/jumps: the operand word follows the
              // instruction, so address memory with the PC
              sel_bus_1    = SEL_PC;
              load_add_reg = 1'b1;
              state_d      = ST_EXEC1;
            end
          endcase
        end
      end

      ST_EXEC1: begin
        if (w_is_alu) begin
          // NOT is unary and operates on dst; the rest take src as operand B
          sel_bus_1  = (w_opcode == OP_NOT) ? w_sel_dst : w_sel_src;
          sel_bus_2  = SEL2_ALU;
          load_reg   = w_dst_hot;
          load_flags = 1'b1;
          instr_done = 1'b1;
          state_d    = ST_FETCH1;
        end else begin
          case (w_opcode)
            OP_REGI, OP_READ: begin
              mem_read  = 1'b1;
              sel_bus_2 = SEL2_MEM;
              if (mem_ready) begin
                load_reg   = w_dst_hot;
                inc_pc     = (w_opcode == OP_REGI);
                instr_done = 1'b1;
                state_d    = ST_FETCH1;
              end
            end
            OP_WRITE: begin
              sel_bus_1 = w_sel_src;
              sel_bus_2 = SEL2_BUS1;
              mem_write = 1'b1;
              if (mem_ready) begin
                instr_done = 1'b1;
                state_d    = ST_FETCH1;
              end
            end
            OP_READI, OP_WRITEI: begin
              // Fetch the pointer word into the address register
              mem_read  = 1'b1;
              sel_bus_2 = SEL2_MEM;
              if (mem_ready) begin
                load_add_reg = 1'b1;
                inc_pc       = 1'b1;
                state_d      = ST_EXEC2;
              end
            end
            OP_JMP, OP_JIZ, OP_JIO: begin
              mem_read  = 1'b1;
              sel_bus_2 = SEL2_MEM;
              if (mem_ready) begin
                load_pc    = w_jmp_taken;
                inc_pc     = !w_jmp_taken;
                instr_done = 1'b1;
                state_d    = ST_FETCH1;
              end
            end
            default: begin
              // NOP/REGD never reach execute; recover to fetch
              state_d = ST_FETCH1;
            end
          endcase
        end
      end

      ST_EXEC2: begin
        if (w_opcode == OP_READI) begin
          mem_read  = 1'b1;
          sel_bus_2 = SEL2_MEM;
          if (mem_ready) begin
            load_reg   = w_dst_hot;
            instr_done = 1'b1;
            state_d    = ST_FETCH1;
          end
        end else if (w_opcode == OP_WRITEI) begin
          sel_bus_1 = w_sel_src;
          sel_bus_2 = SEL2_BUS1;
          mem_write = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            state_d    = ST_FETCH1;
          end
        end else begin
          state_d = ST_FETCH1;
        end
      end

      default: begin
        state_d = ST_FETCH1;
      end
    endcase

    // Reset silences every strobe and memory request immediately,
    // without waiting for the clock edge
    if (rst) begin
      load_reg     = '0;
      load_ir      = 1'b0;
      load_pc      = 1'b0;
      inc_pc       = 1'b0;
      load_add_reg = 1'b0;
      load_reg_y   = 1'b0;
      load_flags   = 1'b0;
      mem_read     = 1'b0;
      mem_write    = 1'b0;
      instr_done   = 1'b0;
    end
  end

  // State register; reset returns to FETCH1 from anywhere, even mid-wait
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH1;
    end else begin
      state_q <= state_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_control_unit
//  Description : Self-checking bench for param_control_unit. A cycle-by-cycle
//                vector table drives the 4-register instance; a short
//                hand-written sequence exercises the 8-register instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_control_unit;

  // Expected/actual output bundle. Strobe byte order:
  // {load_ir, load_pc, inc_pc, load_add_reg, load_reg_y, load_flags, mem_read, mem_write}
  typedef struct packed {
    logic [3:0] lr;
    logic [7:0] st;
    logic [2:0] s1;
    logic [1:0] s2;
    logic       hl;
    logic       dn;
  } out_t;

  typedef struct packed {
    logic       rst;
    logic [7:0] ins;
    logic       z;
    logic       o;
    logic       rdy;
    logic       h;
    logic       dc;   // selects are don't-care (reset cycles)
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // ---------------- 4-register instance ----------------
  logic       rst = 1'b1;
  logic [7:0] instruction = 8'h00;
  logic       zflag = 1'b0, oflag = 1'b0, mem_ready = 1'b0, halt = 1'b0;
  logic [3:0] load_reg;
  logic       load_ir, load_pc, inc_pc, load_add_reg, load_reg_y, load_flags;
  logic       mem_read, mem_write, halted, instr_done;
  logic [2:0] sel_bus_1;
  logic [1:0] sel_bus_2;

  param_control_unit #(.NUM_REGS(4)) dut4 (
    .clk(clk), .rst(rst), .instruction(instruction), .zflag(zflag), .oflag(oflag),
    .mem_ready(mem_ready), .halt(halt), .load_reg(load_reg), .load_ir(load_ir),
    .load_pc(load_pc), .inc_pc(inc_pc), .load_add_reg(load_add_reg),
    .load_reg_y(load_reg_y), .load_flags(load_flags), .mem_read(mem_read),
    .mem_write(mem_write), .sel_bus_1(sel_bus_1), .sel_bus_2(sel_bus_2),
    .halted(halted), .instr_done(instr_done)
  );

  // ---------------- 8-register instance ----------------
  logic       rst8 = 1'b1;
  logic [9:0] instruction8 = 10'd0;
  logic       mem_ready8 = 1'b0, halt8 = 1'b0;
  logic [7:0] load_reg8;
  logic       load_ir8, load_pc8, inc_pc8, load_add_reg8, load_reg_y8, load_flags8;
  logic       mem_read8, mem_write8, halted8, instr_done8;
  logic [3:0] sel_bus_18;
  logic [1:0] sel_bus_28;

  param_control_unit #(.NUM_REGS(8)) dut8 (
    .clk(clk), .rst(rst8), .instruction(instruction8), .zflag(1'b0), .oflag(1'b0),
    .mem_ready(mem_ready8), .halt(halt8), .load_reg(load_reg8), .load_ir(load_ir8),
    .load_pc(load_pc8), .inc_pc(inc_pc8), .load_add_reg(load_add_reg8),
    .load_reg_y(load_reg_y8), .load_flags(load_flags8), .mem_read(mem_read8),
    .mem_write(mem_write8), .sel_bus_1(sel_bus_18), .sel_bus_2(sel_bus_28),
    .halted(halted8), .instr_done(instr_done8)
  );

  vec_t vecs[$];

  function automatic out_t mk(input logic [3:0] lr, input logic [7:0] st,
                              input logic [2:0] s1, input logic [1:0] s2,
                              input logic hl, input logic dn);
    out_t e;
    e.lr = lr; e.st = st; e.s1 = s1; e.s2 = s2; e.hl = hl; e.dn = dn;
    return e;
  endfunction

  task automatic add(input logic r, input logic [7:0] ins, input logic z, input logic o,
                     input logic rdy, input logic h, input logic dc, input out_t e);
    vec_t v;
    v.rst = r; v.ins = ins; v.z = z; v.o = o; v.rdy = rdy; v.h = h; v.dc = dc; v.exp = e;
    vecs.push_back(v);
  endtask

  // FETCH1 then FETCH2 with memory ready at once
  task automatic fetch(input logic [7:0] ins);
    add(0, ins, 0, 0, 1, 0, 0, mk(4'h0, 8'b0001_0000, 3'd4, 2'd0, 0, 0));
    add(0, ins, 0, 0, 1, 0, 0, mk(4'h0, 8'b1010_0010, 3'd0, 2'd2, 0, 0));
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  initial begin
    out_t f1, dec_pc, zero;
    out_t act, exp_v;
    f1     = mk(4'h0, 8'b0001_0000, 3'd4, 2'd0, 0, 0);
    dec_pc = f1;   // DECODE of immediate/jump ops looks like FETCH1
    zero   = mk(4'h0, 8'h00, 3'd0, 2'd0, 0, 0);

    // Reset held two cycles
    add(1, 8'h06, 0, 0, 1, 0, 1, zero);
    add(1, 8'h06, 0, 0, 1, 0, 1, zero);
    // ADD R1,R2
    fetch(8'h06);
    add(0, 8'h06, 0, 0, 1, 0, 0, mk(4'h0, 8'b0000_1000, 3'd1, 2'd0, 0, 0));
    add(0, 8'h06, 0, 0, 1, 0, 0, mk(4'b0010, 8'b0000_0100, 3'd2, 2'd0, 0, 1));
    // JIZ, FETCH2 waits three cycles, zflag=0 -> not taken
    add(0, 8'hE0, 0, 0, 0, 0, 0, f1);
    add(0, 8'hE0, 0, 0, 0, 0, 0, mk(4'h0, 8'b0000_0010, 3'd0, 2'd2, 0, 0));
    add(0, 8'hE0, 0, 0, 0, 0, 0, mk(4'h0, 8'b0000_0010, 3'd0, 2'd2, 0, 0));
    add(0, 8'hE0, 0, 0, 0, 0, 0, mk(4'h0, 8'b0000_0010, 3'd0, 2'd2, 0, 0));
    add(0, 8'hE0, 0, 0, 1, 0, 0, mk(4'h0, 8'b1010_0010, 3'd0, 2'd2, 0, 0));
    add(0, 8'hE0, 0, 0, 1, 0, 0, dec_pc);
    add(0, 8'hE0, 0, 0, 1, 0, 0, mk(4'h0, 8'b0010_0010, 3'd0, 2'd2, 0, 1));
    // JIZ, zflag=1 with one wait cycle -> taken
    fetch(8'hE0);
    add(0, 8'hE0, 1, 0, 1, 0, 0, dec_pc);
    add(0, 8'hE0, 1, 0, 0, 0, 0, mk(4'h0, 8'b0000_0010, 3'd0, 2'd2, 0, 0));
    add(0, 8'hE0, 1, 0, 1, 0, 0, mk(4'h0, 8'b0100_0010, 3'd0, 2'd2, 0, 1));
    // Halt in FETCH1 for two cycles
    add(0, 8'hC3, 0, 0, 1, 1, 0, mk(4'h0, 8'h00, 3'd0, 2'd0, 1, 0));
    add(0, 8'hC3, 0, 0, 1, 1, 0, mk(4'h0, 8'h00, 3'd0, 2'd0, 1, 0));
    // WRITEI src=3, halt raised mid-instruction, reset during EXEC2 wait
    fetch(8'hC3);
    add(0, 8'hC3, 0, 0, 1, 0, 0, dec_pc);
    add(0, 8'hC3, 0, 0, 1, 1, 0, mk(4'h0, 8'b0011_0010, 3'd0, 2'd2, 0, 0));
    add(0, 8'hC3, 0, 0, 0, 1, 0, mk(4'h0, 8'b0000_0001, 3'd3, 2'd1, 0, 0));
    add(1, 8'hC3, 0, 0, 0, 1, 1, zero);
    add(0, 8'hC3, 0, 0, 0, 1, 0, mk(4'h0, 8'h00, 3'd0, 2'd0, 1, 0));
    // READ R1,[R3]: halt during its wait only takes effect afterwards
    fetch(8'h97);
    add(0, 8'h97, 0, 0, 1, 0, 0, mk(4'h0, 8'b0001_0000, 3'd3, 2'd0, 0, 0));
    add(0, 8'h97, 0, 0, 0, 1, 0, mk(4'h0, 8'b0000_0010, 3'd0, 2'd2, 0, 0));
    add(0, 8'h97, 0, 0, 1, 1, 0, mk(4'b0010, 8'b0000_0010, 3'd0, 2'd2, 0, 1));
    add(0, 8'h97, 0, 0, 1, 1, 0, mk(4'h0, 8'h00, 3'd0, 2'd0, 1, 0));
    // NOT R0 (operand is dst)
    fetch(8'h32);
    add(0, 8'h32, 0, 0, 1, 0, 0, mk(4'h0, 8'b0000_1000, 3'd0, 2'd0, 0, 0));
    add(0, 8'h32, 0, 0, 1, 0, 0, mk(4'b0001, 8'b0000_0100, 3'd0, 2'd0, 0, 1));
    // REGD R1<-R2
    fetch(8'h76);
    add(0, 8'h76, 0, 0, 1, 0, 0, mk(4'b0010, 8'h00, 3'd2, 2'd1, 0, 1));
    // REGI R3
    fetch(8'h8C);
    add(0, 8'h8C, 0, 0, 1, 0, 0, dec_pc);
    add(0, 8'h8C, 0, 0, 1, 0, 0, mk(4'b1000, 8'b0010_0010, 3'd0, 2'd2, 0, 1));
    // WRITE [R1]<-R2 with one wait
    fetch(8'hB6);
    add(0, 8'hB6, 0, 0, 1, 0, 0, mk(4'h0, 8'b0001_0000, 3'd1, 2'd0, 0, 0));
    add(0, 8'hB6, 0, 0, 0, 0, 0, mk(4'h0, 8'b0000_0001, 3'd2, 2'd1, 0, 0));
    add(0, 8'hB6, 0, 0, 1, 0, 0, mk(4'h0, 8'b0000_0001, 3'd2, 2'd1, 0, 1));
    // JIO with zflag=1, oflag=0 -> not taken
    fetch(8'hF0);
    add(0, 8'hF0, 1, 0, 1, 0, 0, dec_pc);
    add(0, 8'hF0, 1, 0, 1, 0, 0, mk(4'h0, 8'b0010_0010, 3'd0, 2'd2, 0, 1));
    // JMP -> always taken
    fetch(8'hD0);
    add(0, 8'hD0, 0, 0, 1, 0, 0, dec_pc);
    add(0, 8'hD0, 0, 0, 1, 0, 0, mk(4'h0, 8'b0100_0010, 3'd0, 2'd2, 0, 1));
    // READI R1 with one EXEC2 wait
    fetch(8'hA4);
    add(0, 8'hA4, 0, 0, 1, 0, 0, dec_pc);
    add(0, 8'hA4, 0, 0, 1, 0, 0, mk(4'h0, 8'b0011_0010, 3'd0, 2'd2, 0, 0));
    add(0, 8'hA4, 0, 0, 0, 0, 0, mk(4'h0, 8'b0000_0010, 3'd0, 2'd2, 0, 0));
    add(0, 8'hA4, 0, 0, 1, 0, 0, mk(4'b0010, 8'b0000_0010, 3'd0, 2'd2, 0, 1));
    // NOP, then back at FETCH1
    fetch(8'h60);
    add(0, 8'h60, 0, 0, 1, 0, 0, mk(4'h0, 8'h00, 3'd0, 2'd0, 0, 1));
    add(0, 8'h60, 0, 0, 1, 0, 0, f1);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst         = vecs[k].rst;
      instruction = vecs[k].ins;
      zflag       = vecs[k].z;
      oflag       = vecs[k].o;
      mem_ready   = vecs[k].rdy;
      halt        = vecs[k].h;
      #1;
      act.lr = load_reg;
      act.st = {load_ir, load_pc, inc_pc, load_add_reg, load_reg_y, load_flags, mem_read, mem_write};
      act.s1 = sel_bus_1;
      act.s2 = sel_bus_2;
      act.hl = halted;
      act.dn = instr_done;
      exp_v  = vecs[k].exp;
      if (vecs[k].dc) begin
        act.s1 = '0; act.s2 = '0;
        exp_v.s1 = '0; exp_v.s2 = '0;
      end
      checks++;
      if (act !== exp_v) begin
        failures++;
        $display("FAIL vec%0d: got lr=%h st=%b s1=%0d s2=%0d hl=%b dn=%b want lr=%h st=%b s1=%0d s2=%0d hl=%b dn=%b",
                 k, act.lr, act.st, act.s1, act.s2, act.hl, act.dn,
                 exp_v.lr, exp_v.st, exp_v.s1, exp_v.s2, exp_v.hl, exp_v.dn);
      end
      if (load_pc && inc_pc) begin
        checks++; failures++;
        $display("FAIL vec%0d_pc_excl: got load_pc=1 inc_pc=1 want not both", k);
      end
    end

    // ---- 8-register instance: REGD R7<-R5, then halt at FETCH1 ----
    @(negedge clk);
    rst8 = 1'b1; halt8 = 1'b0; mem_ready8 = 1'b1; instruction8 = 10'b0111_111_101;
    @(negedge clk); #1;
    chk("r8_rst_lar", {31'd0, load_add_reg8}, 32'd0);
    chk("r8_rst_mr", {31'd0, mem_read8}, 32'd0);
    @(negedge clk);
    rst8 = 1'b0; #1;
    chk("r8_f1_sel", {28'd0, sel_bus_18}, 32'd8);
    chk("r8_f1_lar", {31'd0, load_add_reg8}, 32'd1);
    @(negedge clk); #1;
    chk("r8_f2_ir", {31'd0, load_ir8}, 32'd1);
    @(negedge clk); #1;
    chk("r8_regd_sel1", {28'd0, sel_bus_18}, 32'd5);
    chk("r8_regd_sel2", {30'd0, sel_bus_28}, 32'd1);
    chk("r8_regd_lr", {24'd0, load_reg8}, 32'h80);
    chk("r8_regd_done", {31'd0, instr_done8}, 32'd1);
    @(negedge clk);
    halt8 = 1'b1; #1;
    chk("r8_halt_hl", {31'd0, halted8}, 32'd1);
    chk("r8_halt_lar", {31'd0, load_add_reg8}, 32'd0);
    chk("r8_halt_mr", {31'd0, mem_read8}, 32'd0);
    @(negedge clk); #1;
    chk("r8_halt2_hl", {31'd0, halted8}, 32'd1);
    chk("r8_halt2_mr", {31'd0, mem_read8}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/param_control_unit.md
PARAM_CONTROL_UNIT -- requirements
Module: param_control_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: clk is the clock, and rst is sampled only on the rising edge of clk.
REQ-002 Parameter NUM_REGS, default 4: number of general registers; SHALL be a power of two, 2..16.
REQ-003 Derived parameters SHALL be: RSEL_W = log2(NUM_REGS); INSTR_W = 4 + 2*RSEL_W.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 instruction  in  INSTR_W  IR contents: {opcode[3:0], dst[RSEL_W-1:0], src[RSEL_W-1:0]}.
REQ-007 zflag, oflag  in  1 each  zero and overflow flags from the flag register.
REQ-008 mem_ready  in  1  memory completes the current access this cycle.
REQ-009 halt  in  1  request to stop before the next instruction fetch.
REQ-010 load_reg  out  NUM_REGS  one-hot register load strobe; bit i loads register i.
REQ-011 load_ir, load_pc, inc_pc, load_add_reg, load_reg_y, load_flags  out  1 each  datapath strobes.
REQ-012 mem_read, mem_write  out  1 each  memory request, held until mem_ready.
REQ-013 sel_bus_1  out  RSEL_W+1  values 0..NUM_REGS-1 select register; value NUM_REGS selects PC.
REQ-014 sel_bus_2  out  2  0 = ALU, 1 = bus1, 2 = memory.
REQ-015 halted, instr_done  out  1 each  halt status; one-cycle retire pulse.

Function
REQ-016 Opcodes SHALL be: ADD=0, SUB=1, AND=2, NOT=3, MUL=4, OR=5 (ALU group), NOP=6, REGD=7, REGI=8, READ=9, READI=10, WRITE=11, WRITEI=12, JMP=13, JIZ=14, JIO=15.
REQ-017 The FSM SHALL have the states FETCH1, FETCH2, DECODE, EXEC1 and EXEC2; all outputs SHALL be decoded from the state, the instruction and the inputs, and any field not listed SHALL be 0.
REQ-018 FETCH1 with halt=1: the FSM SHALL stay in FETCH1, drive halted=1 and drive every strobe to 0.
REQ-019 FETCH1 with halt=0: sel_bus_1=NUM_REGS, load_add_reg=1; next state FETCH2.
REQ-020 FETCH2: mem_read=1, sel_bus_2=2; on mem_ready, load_ir=1 and inc_pc=1 and the next state is DECODE.
REQ-021 DECODE, NOP: instr_done=1; next state FETCH1.
REQ-022 DECODE, REGD: sel_bus_1=src, sel_bus_2=1, load_reg[dst]=1, instr_done=1; next state FETCH1.
REQ-023 DECODE, ALU group: sel_bus_1=dst, load_reg_y=1; next state EXEC1.
REQ-024 DECODE, READ: sel_bus_1=src, load_add_reg=1; next state EXEC1.
REQ-025 DECODE, WRITE: sel_bus_1=dst, load_add_reg=1; next state EXEC1.
REQ-026 DECODE, REGI/READI/WRITEI/JMP/JIZ/JIO: sel_bus_1=NUM_REGS, load_add_reg=1; next state EXEC1.
REQ-027 EXEC1, ALU group: sel_bus_1 SHALL be dst for NOT and src otherwise; sel_bus_2=0, load_reg[dst]=1, load_flags=1, instr_done=1; next state FETCH1.
REQ-028 EXEC1, REGI and READ: mem_read=1, sel_bus_2=2; on mem_ready, load_reg[dst]=1 (and inc_pc=1 for REGI only) and instr_done=1; next state FETCH1.
REQ-029 EXEC1, WRITE: sel_bus_1=src, sel_bus_2=1, mem_write=1; on mem_ready, instr_done=1; next state FETCH1.
REQ-030 EXEC1, READI/WRITEI: mem_read=1, sel_bus_2=2; on mem_ready, load_add_reg=1 and inc_pc=1; next state EXEC2.
REQ-031 EXEC1, jumps: mem_read=1, sel_bus_2=2. On mem_ready, the jump is taken for JMP, for JIZ with zflag=1 and for JIO with oflag=1; taken gives load_pc=1, not taken gives inc_pc=1. Also on mem_ready: instr_done=1, next state FETCH1. Flags SHALL be sampled in the mem_ready cycle.
REQ-032 EXEC2, READI: mem_read=1, sel_bus_2=2; on mem_ready, load_reg[dst]=1 and instr_done=1; next state FETCH1.
REQ-033 EXEC2, WRITEI: sel_bus_1=src, sel_bus_2=1, mem_write=1; on mem_ready, instr_done=1; next state FETCH1.
REQ-034 Wait states: while mem_ready=0, the state SHALL hold; mem_read/mem_write and the selects SHALL stay stable; load, inc and instr_done strobes SHALL stay 0.
REQ-035 load_pc and inc_pc SHALL never be asserted together, and mem_read and mem_write SHALL never be asserted together.
REQ-036 halt asserted outside FETCH1 SHALL take effect only on the next return to FETCH1; the current instruction SHALL complete.

Reset
REQ-037 While rst=1, all strobes, mem_read, mem_write and instr_done SHALL be forced to 0 combinationally.
REQ-038 The first edge with rst=1 SHALL set the state to FETCH1 from any state, including a memory wait; halted SHALL then follow halt.

Verification
REQ-039 Reset: rst=1 for 2 cycles, halt=0 -> all strobes 0; first cycle after release shows sel_bus_1=4 and load_add_reg=1.
REQ-040 ADD R1,R2 (instruction 0x06), mem_ready=1 -> 4 cycles; EXEC1 shows sel_bus_1=2, sel_bus_2=0, load_reg=4'b0010, load_flags=1, instr_done=1.
REQ-041 FETCH2 with mem_ready=0 for 3 cycles -> mem_read=1 for 4 cycles; load_ir and inc_pc are set only in the 4th cycle.
REQ-042 JIZ (0xE0) -> with zflag=0, EXEC1 shows inc_pc=1, load_pc=0; with zflag=1, EXEC1 shows load_pc=1, inc_pc=0.
REQ-043 WRITEI src=3 (0xC3) -> EXEC2 shows sel_bus_1=3, sel_bus_2=1, mem_write=1 until mem_ready. Assert rst during this wait -> FETCH1 next cycle, mem_write=0.
REQ-044 NUM_REGS=8: REGD dst=7, src=5 (10'b0111_111_101) -> sel_bus_1=5, load_reg=8'h80. halt=1 at FETCH1 -> halted=1 and no fetch issued.
